// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped machine timer. The CEP address
// decoder imports this package too, so register indices and CTRL layout live
// here rather than inside the timer.
//   - IDX_*        : word indices (byte address bits [4:2]) of each register
//   - CTRL_*       : bit positions of the CTRL register fields
//   - ctrl_t       : packed view of CTRL {div, en}
//   - ctrl_word()  : builds the 32-bit CTRL bus word from a ctrl_t
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam logic [2:0] IDX_MTIME_LO    = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI    = 3'd1;
    localparam logic [2:0] IDX_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] IDX_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] IDX_CTRL        = 3'd4;

    // CTRL layout: en in bit 0, prescaler divide field starting at bit 8.
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_W   = 8;

    typedef struct packed {
        logic [CTRL_DIV_W-1:0] div;
        logic                  en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]                 = c.en;
        w[CTRL_DIV_LSB +: CTRL_DIV_W]  = c.div;
        return w;
    endfunction

endpackage

// File: rtl/machine_timer_if.sv
// ---------------------------------------------------------------------------
// machine_timer_if
// Single-cycle peripheral bus between the writeback-stage load/store path
// (master) and the machine timer (slave).
//   sel    : chip select from the address decoder
//   wr/rd  : write / read strobes, qualified by sel
//   addr   : byte address, ADDR_W bits
//   wdata  : write data
//   rdata  : registered read data, valid while rvalid is high
//   rvalid : one-cycle pulse, the cycle after a read strobe
// ---------------------------------------------------------------------------
interface machine_timer_if #(
    parameter int ADDR_W = 5
);
    logic              sel;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;

    modport master (
        output sel, wr, rd, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  sel, wr, rd, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Divides the clock into mtime ticks. The counter runs 0..div while run is
// high; the cycle it sits at div it asserts tick and wraps to 0. With run
// low it holds and tick stays low. clr forces the counter back to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count enable (CTRL.en & timer_en)
//   clr        : synchronous counter clear
//   div        : divide value, tick every div+1 run cycles
//   tick       : one-cycle increment request for mtime
// ---------------------------------------------------------------------------
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  w_at_div;

    // >= rather than == so a counter left above a freshly lowered div still
    // wraps instead of running all the way round.
    assign w_at_div = (r_cnt >= div);
    assign tick     = run & w_at_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_at_div ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// ---------------------------------------------------------------------------
// machine_timer
// RISC-V machine timer (mtime / mtimecmp) on a single-cycle peripheral bus.
// Drives the level-sensitive timer interrupt read by the CSR file as MTIP.
//   clk           : processor clock
//   rst_n         : asynchronous active-low reset
//   timer_en      : board-level enable, ANDed with CTRL.en for counting
//   counter_clear : synchronous clear of mtime and the prescaler
//   bus           : peripheral bus slave (sel/wr/rd/addr/wdata/rdata/rvalid)
//   timer_inter   : registered CTRL.en & (mtime >= mtimecmp)
// Register words (addr[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
// 3 MTIMECMP_HI, 4 CTRL {div[15:8], en[0]}, 5-7 read as zero.
// ---------------------------------------------------------------------------
module machine_timer
    import timer_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter int          PRESCALE_W = 8,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            timer_en,
    input  logic            counter_clear,
    machine_timer_if.slave  bus,
    output logic            timer_inter
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic                  r_ctrl_en;
    logic [PRESCALE_W-1:0] r_ctrl_div;
    logic [31:0]           r_rdata;
    logic                  r_rvalid;
    logic                  r_timer_inter;

    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_rd;
    logic        w_run;
    logic        w_tick;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_wr_ctrl;
    logic [1:0]  w_wr_cmp;
    logic [31:0] w_rdata_mux;
    logic        w_unused_addr;

    assign w_idx  = bus.addr[4:2];
    assign w_wr   = bus.sel & bus.wr;
    assign w_rd   = bus.sel & bus.rd;
    assign w_run  = r_ctrl_en & timer_en;

    assign w_wr_mtime_lo = w_wr && (w_idx == IDX_MTIME_LO);
    assign w_wr_mtime_hi = w_wr && (w_idx == IDX_MTIME_HI);
    assign w_wr_cmp[0]   = w_wr && (w_idx == IDX_MTIMECMP_LO);
    assign w_wr_cmp[1]   = w_wr && (w_idx == IDX_MTIMECMP_HI);
    assign w_wr_ctrl     = w_wr && (w_idx == IDX_CTRL);

    // Only addr[4:2] is decoded; byte-lane bits and any upper bits are ignored.
    assign w_unused_addr = ^bus.addr[ADDR_W-1:0];

    // A CTRL write restarts the prescale period so a new div takes effect
    // from a clean phase.
    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (counter_clear | w_wr_ctrl),
        .div   (r_ctrl_div),
        .tick  (w_tick)
    );

    // mtime: clear beats a bus load, and a bus load swallows the tick of the
    // same cycle so software sees exactly the value it wrote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime <= '0;
        end else if (counter_clear) begin
            r_mtime <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= bus.wdata;
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= bus.wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp halves are independent 32-bit registers.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cmp_half
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mtimecmp[gi*32 +: 32] <= CMP_RESET[gi*32 +: 32];
                end else if (w_wr_cmp[gi]) begin
                    r_mtimecmp[gi*32 +: 32] <= bus.wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_en  <= 1'b0;
            r_ctrl_div <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl_en  <= bus.wdata[CTRL_EN_BIT];
            r_ctrl_div <= bus.wdata[CTRL_DIV_LSB +: PRESCALE_W];
        end
    end

    // Read mux sees pre-write register values, so a combined write+read
    // returns the old contents.
    always_comb begin
        w_rdata_mux = '0;
        case (w_idx)
            IDX_MTIME_LO:    w_rdata_mux = r_mtime[31:0];
            IDX_MTIME_HI:    w_rdata_mux = r_mtime[63:32];
            IDX_MTIMECMP_LO: w_rdata_mux = r_mtimecmp[31:0];
            IDX_MTIMECMP_HI: w_rdata_mux = r_mtimecmp[63:32];
            IDX_CTRL: begin
                w_rdata_mux[CTRL_EN_BIT]                = r_ctrl_en;
                w_rdata_mux[CTRL_DIV_LSB +: PRESCALE_W] = r_ctrl_div;
            end
            default:         w_rdata_mux = '0;
        endcase
    end

    // rdata holds between reads; rvalid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_mux;
            end
        end
    end

    // timer_en is deliberately absent: pausing the count must not hide an
    // interrupt that is already due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer_inter <= 1'b0;
        end else begin
            r_timer_inter <= r_ctrl_en & (r_mtime >= r_mtimecmp);
        end
    end

    assign bus.rdata   = r_rdata;
    assign bus.rvalid  = r_rvalid;
    assign timer_inter = r_timer_inter;

endmodule

// File: tb/tb_machine_timer.sv
// ---------------------------------------------------------------------------
// tb_machine_timer
// Directed stimulus for machine_timer with a behavioural reference model.
// The model keeps mtime/mtimecmp/CTRL as plain values and decides ticks from
// the number of running cycles since the last prescaler restart; a compare
// process checks rvalid, rdata and timer_inter against it every cycle, and
// the stimulus block pins the model with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_machine_timer;

    logic clk;
    logic rst_n;
    logic timer_en;
    logic counter_clear;
    logic timer_inter;

    int n_tests = 0;
    int n_fail  = 0;

    machine_timer_if #(.ADDR_W(5)) bif ();

    machine_timer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .timer_en      (timer_en),
        .counter_clear (counter_clear),
        .bus           (bif),
        .timer_inter   (timer_inter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [7:0]  m_div;
    int          m_runs;      // running cycles since the prescaler last restarted
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_inter;

    logic       mt_run;
    logic       mt_tick;
    logic       mt_wr;
    logic       mt_rd;
    logic [2:0] mt_idx;

    assign mt_run  = m_en & timer_en;
    // Every (div+1)-th running cycle is a tick.
    assign mt_tick = mt_run && ((m_runs % (int'(m_div) + 1)) == int'(m_div));
    assign mt_wr   = bif.sel & bif.wr;
    assign mt_rd   = bif.sel & bif.rd;
    assign mt_idx  = bif.addr[4:2];

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return m_mtime[31:0];
            3'd1:    return m_mtime[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {16'h0, m_div, 7'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime  <= 64'd0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_en     <= 1'b0;
            m_div    <= 8'd0;
            m_runs   <= 0;
            m_rdata  <= 32'd0;
            m_rvalid <= 1'b0;
            m_inter  <= 1'b0;
        end else begin
            m_rvalid <= mt_rd;
            if (mt_rd) m_rdata <= model_read(mt_idx);
            m_inter <= m_en && (m_mtime >= m_cmp);

            if (counter_clear)                m_mtime <= 64'd0;
            else if (mt_wr && mt_idx == 3'd0) m_mtime <= {m_mtime[63:32], bif.wdata};
            else if (mt_wr && mt_idx == 3'd1) m_mtime <= {bif.wdata, m_mtime[31:0]};
            else if (mt_tick)                 m_mtime <= m_mtime + 64'd1;

            if (counter_clear || (mt_wr && mt_idx == 3'd4)) m_runs <= 0;
            else if (mt_run)                                m_runs <= m_runs + 1;

            if (mt_wr && mt_idx == 3'd2) m_cmp[31:0]  <= bif.wdata;
            if (mt_wr && mt_idx == 3'd3) m_cmp[63:32] <= bif.wdata;
            if (mt_wr && mt_idx == 3'd4) begin
                m_en  <= bif.wdata[0];
                m_div <= bif.wdata[15:8];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cyc_rvalid", {63'd0, bif.rvalid}, {63'd0, m_rvalid});
            check("cyc_rdata",  {32'd0, bif.rdata},  {32'd0, m_rdata});
            check("cyc_inter",  {63'd0, timer_inter}, {63'd0, m_inter});
        end
    end

    // ---------------- bus tasks (called just after a rising edge) ----------------
    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        bif.sel   = 1'b1;
        bif.wr    = 1'b1;
        bif.addr  = {idx, 2'b00};
        bif.wdata = data;
        @(posedge clk); #1;
        bif.sel = 1'b0;
        bif.wr  = 1'b0;
        $display("[TB] write idx=%0d data=%h", idx, data);
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
        bif.sel  = 1'b1;
        bif.rd   = 1'b1;
        bif.addr = {idx, 2'b00};
        @(posedge clk); #1;
        bif.sel = 1'b0;
        bif.rd  = 1'b0;
        data = bif.rdata;
        $display("[TB] read  idx=%0d data=%h rvalid=%0b", idx, data, bif.rvalid);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] v;
        int          rise;

        rst_n         = 1'b0;
        timer_en      = 1'b0;
        counter_clear = 1'b0;
        bif.sel       = 1'b0;
        bif.wr        = 1'b0;
        bif.rd        = 1'b0;
        bif.addr      = '0;
        bif.wdata     = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata",  {32'd0, bif.rdata},  64'd0);
        check("rst_rvalid", {63'd0, bif.rvalid}, 64'd0);
        check("rst_inter",  {63'd0, timer_inter}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd3, v);
        check("rst_cmp_hi", {32'd0, v}, 64'h0000_0000_FFFF_FFFF);
        check("rst_rvalid_pulse", {63'd0, bif.rvalid}, 64'd1);

        // Count / prescale: div=3, 40 cycles gives 10 ticks
        timer_en = 1'b1;
        bus_write(3'd4, 32'h0000_0301);
        repeat (40) @(posedge clk);
        #1;
        bus_read(3'd0, v);
        check("count_div3", {32'd0, v}, 64'd10);
        timer_en = 1'b0;
        bus_read(3'd0, v);
        check("freeze_a", {32'd0, v}, 64'd10);
        repeat (6) @(posedge clk);
        #1;
        bus_read(3'd0, v);
        check("freeze_b", {32'd0, v}, 64'd10);
        timer_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Carry from LO into HI, then full 64-bit wrap
        bus_write(3'd4, 32'h0000_0001);
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        timer_en = 1'b0;
        bus_read(3'd1, v);
        check("carry_hi", {32'd0, v}, 64'd1);
        bus_read(3'd0, v);
        check("carry_lo", {32'd0, v}, 64'd0);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_write(3'd0, 32'hFFFF_FFFF);
        timer_en = 1'b1;
        @(posedge clk); #1;
        timer_en = 1'b0;
        bus_read(3'd1, v);
        check("wrap_hi", {32'd0, v}, 64'd0);
        bus_read(3'd0, v);
        check("wrap_lo", {32'd0, v}, 64'd0);

        // Interrupt: mtimecmp=5, counting from 0 every cycle
        bus_write(3'd3, 32'h0);
        bus_write(3'd2, 32'd5);
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'h0);
        check("irq_idle", {63'd0, timer_inter}, 64'd0);
        timer_en = 1'b1;
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (timer_inter === 1'b1 && rise == 0) rise = i;
        end
        check("irq_rise_cycle", 64'(rise), 64'd6);
        bus_write(3'd2, 32'd100);
        check("irq_still_high", {63'd0, timer_inter}, 64'd1);
        @(posedge clk); #1;
        check("irq_cleared", {63'd0, timer_inter}, 64'd0);
        $display("[TB] irq rose after %0d cycles", rise);

        // Priority: clear beats write; write beats tick
        counter_clear = 1'b1;
        bus_write(3'd0, 32'd50);
        counter_clear = 1'b0;
        bus_read(3'd0, v);
        check("clear_vs_write_lo", {32'd0, v}, 64'd0);
        bus_read(3'd1, v);
        check("clear_vs_write_hi", {32'd0, v}, 64'd0);
        bus_write(3'd0, 32'd1000);
        bus_read(3'd0, v);
        check("write_vs_tick", {32'd0, v}, 64'd1000);

        // Simultaneous write and read returns the pre-write value
        bif.sel   = 1'b1;
        bif.wr    = 1'b1;
        bif.rd    = 1'b1;
        bif.addr  = {3'd2, 2'b00};
        bif.wdata = 32'd7;
        @(posedge clk); #1;
        bif.sel = 1'b0;
        bif.wr  = 1'b0;
        bif.rd  = 1'b0;
        check("wr_rd_old", {32'd0, bif.rdata}, 64'd100);
        bus_read(3'd2, v);
        check("wr_rd_new", {32'd0, v}, 64'd7);
        @(posedge clk); #1;
        check("pre_reset_inter", {63'd0, timer_inter}, 64'd1);

        // Asynchronous reset in the middle of a read
        bif.sel  = 1'b1;
        bif.rd   = 1'b1;
        bif.addr = {3'd1, 2'b00};
        @(posedge clk); #2;
        check("mid_read_rvalid", {63'd0, bif.rvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rvalid", {63'd0, bif.rvalid}, 64'd0);
        check("async_rdata",  {32'd0, bif.rdata},  64'd0);
        check("async_inter",  {63'd0, timer_inter}, 64'd0);
        bif.sel = 1'b0;
        bif.rd  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd3, v);
        check("post_rst_cmp_hi", {32'd0, v}, 64'h0000_0000_FFFF_FFFF);
        bus_read(3'd2, v);
        check("post_rst_cmp_lo", {32'd0, v}, 64'h0000_0000_FFFF_FFFF);
        bus_read(3'd0, v);
        check("post_rst_mtime_lo", {32'd0, v}, 64'd0);
        bus_read(3'd4, v);
        check("post_rst_ctrl", {32'd0, v}, 64'd0);
        bus_read(3'd6, v);
        check("reserved_read", {32'd0, v}, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped RISC-V machine timer (mtime/mtimecmp) sitting directly upstream of the CSR unit in the CEP top.
- Produces the level-sensitive timer interrupt consumed as timer_inter by the CSR register file (mip.MTIP).
- Accessed by the processor's writeback-stage load/store path over a simple single-cycle peripheral bus.
- Gated by the board-level timer_en and counter_clear inputs.

Parameters:
- ADDR_W, 5: byte-address width of the peripheral window; only addr[4:2] is decoded.
- PRESCALE_W, 8: width of the prescaler divide field in CTRL.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp, chosen so no interrupt fires out of reset.

Ports:
- clk  in  1  single clock; the processor clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- timer_en  in  1  external enable; ANDed with CTRL.en.
- counter_clear  in  1  synchronous clear of mtime and the prescaler.
- sel  in  1  peripheral chip select, from address decode.
- wr  in  1  write strobe; qualified by sel.
- rd  in  1  read strobe; qualified by sel.
- addr  in  ADDR_W  byte address.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- rvalid  out  1  one-cycle pulse; rdata is valid in that cycle.
- timer_inter  out  1  registered interrupt level to CSR.

Behaviour:
Register map, word index addr[4:2]:
- 0: MTIME_LO
- 1: MTIME_HI
- 2: MTIMECMP_LO
- 3: MTIMECMP_HI
- 4: CTRL. Bit 0 is en. Bits [8+PRESCALE_W-1:8] are div.
- 5-7: reserved. Reads return 0; writes are ignored.

Reset (rst_n=0, asynchronous):
- mtime=0, mtimecmp=CMP_RESET, CTRL=0, prescaler=0.
- rdata=0, rvalid=0, timer_inter=0.

Tick generation:
- Active when run = CTRL.en & timer_en.
- The prescaler counts 0..div. When it reaches div it wraps to 0 and asserts tick for one cycle.
- div=0 gives a tick every cycle; div=N gives a tick every N+1 cycles.
- When run=0, the prescaler holds its value and tick=0.

mtime update, per cycle, in priority order:
1. counter_clear=1: mtime<=0 and prescaler<=0. A bus write to mtime in the same cycle is dropped.
2. Bus write to MTIME_LO or MTIME_HI: only that 32-bit half is loaded; the other half holds. This cycle's tick is discarded, with no increment and no carry.
3. tick=1: mtime<=mtime+1 as a full 64-bit increment with carry from LO into HI. 2^64-1 wraps to 0.

Other writes:
- mtimecmp halves are written independently; counter_clear does not affect them.
- A write to CTRL resets the prescaler to 0.

Reads:
- A read with sel&rd in cycle T returns in cycle T+1: rdata=register value sampled at T, rvalid=1.
- rdata holds its value until the next read. rvalid is 0 otherwise.
- sel&wr&rd together: the write takes effect, and the read returns the pre-write value.

Interrupt:
- timer_inter <= CTRL.en & (mtime >= mtimecmp), as an unsigned 64-bit compare of the current register values.
- Latency: one cycle after the state change.
- Level-sensitive. It deasserts only when mtimecmp is raised above mtime, mtime is cleared, or CTRL.en=0.
- timer_en=0 stops counting but does not mask an already-satisfied compare.

Non-atomic 64-bit access:
- Software is responsible for consistency: read HI/LO/HI; write mtimecmp as LO=all-ones, then HI, then LO.
- Hardware provides no shadow register.

Reset mid-operation:
- Asserting rst_n=0 overrides everything immediately, including an in-flight read (rvalid drops to 0).

Decomposition:
- timer_pkg holds:
  - register index constants: IDX_MTIME_LO, IDX_MTIME_HI, IDX_MTIMECMP_LO, IDX_MTIMECMP_HI, IDX_CTRL;
  - CTRL bit positions;
  - a packed ctrl_t struct {div, en}.
- The CEP address decoder imports the same package.
- One sub-module, timer_prescaler: inputs clk, rst_n, run, clr, div; output tick.
- All register, bus and compare logic stays in machine_timer.

Test Plan:
- Reset: drive rst_n=0 then release. Required: rdata=0, rvalid=0, timer_inter=0. Reading MTIMECMP_HI returns 32'hFFFF_FFFF one cycle later with rvalid=1.
- Count/prescale: write CTRL=32'h0000_0301 (en=1, div=3) with timer_en=1, then wait 40 cycles. Required: MTIME_LO reads 10. Timer_en=0 for 8 cycles then 1: count frozen during the gap.
- Carry/wrap: write MTIME_HI=0, MTIME_LO=32'hFFFF_FFFF, div=0. Required: next tick gives MTIME_HI=1, LO=0. Loading 2^64-1 wraps to 0 with no X.
- Interrupt: mtime=0, mtimecmp=5, div=0, en=1. Required: timer_inter rises on the cycle after mtime reaches 5. Writing MTIMECMP_LO=100 clears it the next cycle.
- Priority collision: counter_clear=1 and a write MTIME_LO=50 in the same cycle. Required: mtime=0. A write plus tick in the same cycle gives exactly the written value.
- Async reset mid-read: issue a read, then pull rst_n low before the next edge. Required: rvalid=0 immediately; all registers return to their reset values.
